// File: rtl/pipe_wb_chain.sv
// pipe_wb_chain: DEPTH-stage write-back pipeline carrying {valid, RegWrite, Rd, data}
// with global stall, flush (bubble insertion) and a two-port forwarding lookup that
// scans every in-flight stage, youngest first.
// Optional feature macro: PIPE_WB_PERF_EN (stall-cycle and killed-entry counters).
module pipe_wb_chain #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_RegWrite,
    input  logic [4:0]       in_Rd,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_RegWrite,
    output logic [4:0]       out_Rd,
    output logic [WIDTH-1:0] out_data,
    input  logic [4:0]       query_a,
    input  logic [4:0]       query_b,
    output logic             fwd_hit_a,
    output logic             fwd_hit_b,
    output logic [WIDTH-1:0] fwd_data_a,
    output logic [WIDTH-1:0] fwd_data_b,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_kill_cnt
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic             we_q    [DEPTH];
    logic             we_d    [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rd_d    [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0] live_c;

    // Next-state: flush kills everything, stall holds, otherwise shift toward the output.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            valid_d[k] = valid_q[k];
            we_d[k]    = we_q[k];
            rd_d[k]    = rd_q[k];
            data_d[k]  = data_q[k];
        end
        if (flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                valid_d[k] = 1'b0;
                we_d[k]    = 1'b0;
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            we_d[0]    = in_valid & in_RegWrite;
            rd_d[0]    = in_Rd;
            data_d[0]  = in_data;
            for (int k = 1; k < int'(DEPTH); k++) begin
                valid_d[k] = valid_q[k-1];
                we_d[k]    = we_q[k-1];
                rd_d[k]    = rd_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                valid_q[k] <= 1'b0;
                we_q[k]    <= 1'b0;
                rd_q[k]    <= 5'd0;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                valid_q[k] <= valid_d[k];
                we_q[k]    <= we_d[k];
                rd_q[k]    <= rd_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    assign out_valid    = valid_q[DEPTH-1];
    assign out_RegWrite = valid_q[DEPTH-1] & we_q[DEPTH-1];
    assign out_Rd       = rd_q[DEPTH-1];
    assign out_data     = data_q[DEPTH-1];

    // Forwarding lookup: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        live_c     = '0;
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            live_c[k] = valid_q[k] & we_q[k] & (rd_q[k] != ZR);
        end
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (live_c[k] && (rd_q[k] == query_a) && (query_a != ZR)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = data_q[k];
            end
            if (live_c[k] && (rd_q[k] == query_b) && (query_b != ZR)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = data_q[k];
            end
        end
    end

`ifdef PIPE_WB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] kill_cnt_q;
    logic [31:0] kill_cnt_d;
    logic [31:0] kill_add_c;

    // Counter next-state: count stalled cycles and every valid entry a flush discards.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        kill_add_c  = 32'(in_valid);
        for (int k = 0; k < int'(DEPTH); k++) begin
            kill_add_c = kill_add_c + 32'(valid_q[k]);
        end
        if (flush) begin
            kill_cnt_d = kill_cnt_q + kill_add_c;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_kill_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_wb_chain.sv
// Bench for pipe_wb_chain (DEPTH=2, WIDTH=64): a directed vector table, hand-written
// stall / async-reset sequences, then random traffic against a queue-based model.
module tb_pipe_wb_chain;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 2;
`ifdef PIPE_WB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             stall, flush, in_valid, in_RegWrite;
    logic [4:0]       in_Rd, query_a, query_b;
    logic [WIDTH-1:0] in_data;
    logic             out_valid, out_RegWrite, fwd_hit_a, fwd_hit_b;
    logic [4:0]       out_Rd;
    logic [WIDTH-1:0] out_data, fwd_data_a, fwd_data_b;
    logic [31:0]      perf_stall_cnt, perf_kill_cnt;

    int checks = 0;
    int failures = 0;

    pipe_wb_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_Rd(in_Rd), .in_data(in_data),
        .out_valid(out_valid), .out_RegWrite(out_RegWrite), .out_Rd(out_Rd), .out_data(out_data),
        .query_a(query_a), .query_b(query_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight entries as a queue, index 0 youngest.
    typedef struct {
        bit          v;
        bit          we;
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_stall, m_kill;

    task automatic model_reset();
        ent_t e;
        e = '{0, 0, 5'd0, 64'd0};
        mq.delete();
        for (int i = 0; i < int'(DEPTH); i++) mq.push_back(e);
        m_stall = 0;
        m_kill  = 0;
    endtask

    task automatic model_clk();
        ent_t e;
        int   n;
        if (flush) begin
            n = int'(in_valid);
            foreach (mq[i]) if (mq[i].v) n++;
            m_kill = m_kill + 32'(n);
            foreach (mq[i]) begin
                mq[i].v  = 0;
                mq[i].we = 0;
            end
        end else if (stall) begin
            m_stall = m_stall + 32'd1;
        end else begin
            e = '{in_valid, in_valid & in_RegWrite, in_Rd, in_data};
            mq.push_front(e);
            void'(mq.pop_back());
        end
    endtask

    function automatic logic [64:0] model_fwd(input logic [4:0] q);
        if (q == 5'd31) return 65'd0;
        foreach (mq[i]) begin
            if (mq[i].v && mq[i].we && mq[i].rd != 5'd31 && mq[i].rd == q)
                return {1'b1, mq[i].d};
        end
        return 65'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit st, input bit fl, input bit v, input bit we,
                         input logic [4:0] rd, input logic [63:0] d,
                         input logic [4:0] qa, input logic [4:0] qb);
        stall = st; flush = fl; in_valid = v; in_RegWrite = we;
        in_Rd = rd; in_data = d; query_a = qa; query_b = qb;
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [64:0] fa, fb;
        ent_t        o;
        o  = mq[DEPTH-1];
        fa = model_fwd(query_a);
        fb = model_fwd(query_b);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(o.v));
        chk({tag, ".out_RegWrite"}, 64'(out_RegWrite), 64'(o.v & o.we));
        if (o.v) begin
            chk({tag, ".out_Rd"}, 64'(out_Rd), 64'(o.rd));
            chk({tag, ".out_data"}, out_data, o.d);
        end
        chk({tag, ".hit_a"}, 64'(fwd_hit_a), 64'(fa[64]));
        chk({tag, ".data_a"}, fwd_data_a, fa[63:0]);
        chk({tag, ".hit_b"}, 64'(fwd_hit_b), 64'(fb[64]));
        chk({tag, ".data_b"}, fwd_data_b, fb[63:0]);
        chk({tag, ".perf_stall"}, 64'(perf_stall_cnt), PERF ? 64'(m_stall) : 64'd0);
        chk({tag, ".perf_kill"}, 64'(perf_kill_cnt), PERF ? 64'(m_kill) : 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_RegWrite"}, 64'(out_RegWrite), 64'd0);
        chk({tag, ".out_Rd"}, 64'(out_Rd), 64'd0);
        chk({tag, ".out_data"}, out_data, 64'd0);
        chk({tag, ".hit_a"}, 64'(fwd_hit_a), 64'd0);
        chk({tag, ".data_a"}, fwd_data_a, 64'd0);
        chk({tag, ".hit_b"}, 64'(fwd_hit_b), 64'd0);
        chk({tag, ".perf_stall"}, 64'(perf_stall_cnt), 64'd0);
        chk({tag, ".perf_kill"}, 64'(perf_kill_cnt), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 0; flush = 0; in_valid = 0; in_RegWrite = 0;
        in_Rd = 0; in_data = 0; query_a = 0; query_b = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_zero("reset");
        reset = 1'b0;
    endtask

    typedef struct {
        bit          st, fl, v, we;
        logic [4:0]  rd;
        logic [63:0] d;
        logic [4:0]  qa;
        bit          eov, eowe, crd;
        logic [4:0]  erd;
        logic [63:0] ed;
        bit          eha;
        logic [63:0] eda;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [4:0] pick_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        // Expected values are the state after the edge that consumes each vector.
        tbl[0] = '{0,0,1,1, 5'd5,  64'hAA, 5'd5,  0,0,1, 5'd0,  64'h0,  1, 64'hAA};
        tbl[1] = '{0,0,1,1, 5'd9,  64'h11, 5'd5,  1,1,1, 5'd5,  64'hAA, 1, 64'hAA};
        tbl[2] = '{0,0,1,1, 5'd9,  64'h22, 5'd9,  1,1,1, 5'd9,  64'h11, 1, 64'h22};
        tbl[3] = '{1,0,1,1, 5'd7,  64'h77, 5'd7,  1,1,1, 5'd9,  64'h11, 0, 64'h0};
        tbl[4] = '{0,0,1,1, 5'd31, 64'h33, 5'd31, 1,1,1, 5'd9,  64'h22, 0, 64'h0};
        tbl[5] = '{0,0,1,0, 5'd8,  64'h44, 5'd8,  1,1,1, 5'd31, 64'h33, 0, 64'h0};
        tbl[6] = '{1,1,1,1, 5'd3,  64'h66, 5'd8,  0,0,0, 5'd0,  64'h0,  0, 64'h0};
        tbl[7] = '{0,0,0,1, 5'd12, 64'h55, 5'd12, 0,0,0, 5'd0,  64'h0,  0, 64'h0};
        tbl[8] = '{0,0,0,0, 5'd0,  64'h0,  5'd12, 0,0,1, 5'd12, 64'h55, 0, 64'h0};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].d,
                  tbl[i].qa, 5'd31);
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            chk($sformatf("vec%0d.out_RegWrite", i), 64'(out_RegWrite), 64'(tbl[i].eowe));
            if (tbl[i].crd) begin
                chk($sformatf("vec%0d.out_Rd", i), 64'(out_Rd), 64'(tbl[i].erd));
                chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].ed);
            end
            chk($sformatf("vec%0d.hit_a", i), 64'(fwd_hit_a), 64'(tbl[i].eha));
            chk($sformatf("vec%0d.data_a", i), fwd_data_a, tbl[i].eda);
            chk($sformatf("vec%0d.hit_b_zr", i), 64'(fwd_hit_b), 64'd0);
        end
        chk("table.perf_stall", 64'(perf_stall_cnt), PERF ? 64'd1 : 64'd0);
        chk("table.perf_kill", 64'(perf_kill_cnt), PERF ? 64'd3 : 64'd0);

        // Stall hold: Rd=5 sits in stage0 while Rd=7 is offered and dropped.
        do_reset();
        drive(0, 0, 1, 1, 5'd5, 64'hAA, 5'd5, 5'd7);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 1, 1, 5'd7, 64'h77, 5'd5, 5'd7);
            chk($sformatf("stall%0d.out_valid", c), 64'(out_valid), 64'd0);
            chk($sformatf("stall%0d.hit5", c), 64'(fwd_hit_a), 64'd1);
            chk($sformatf("stall%0d.hit7", c), 64'(fwd_hit_b), 64'd0);
        end
        drive(0, 0, 0, 0, 5'd0, 64'h0, 5'd7, 5'd5);
        chk("stall_rel.out_valid", 64'(out_valid), 64'd1);
        chk("stall_rel.out_RegWrite", 64'(out_RegWrite), 64'd1);
        chk("stall_rel.out_Rd", 64'(out_Rd), 64'd5);
        chk("stall_rel.out_data", out_data, 64'hAA);
        chk("stall_rel.hit7", 64'(fwd_hit_a), 64'd0);
        drive(0, 0, 0, 0, 5'd0, 64'h0, 5'd7, 5'd5);
        chk("stall_rel2.out_valid", 64'(out_valid), 64'd0);

        // Async reset between edges with a full pipeline.
        drive(0, 0, 1, 1, 5'd3, 64'h1234, 5'd3, 5'd4);
        drive(1, 0, 1, 1, 5'd4, 64'h5678, 5'd3, 5'd4);
        drive(0, 0, 1, 1, 5'd4, 64'h5678, 5'd3, 5'd4);
        chk("pre_rst.out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst.hit_b", 64'(fwd_hit_b), 64'd1);
        #2 reset = 1'b1;
        #1;
        query_b = 5'd4;
        check_zero("async_rst");
        model_reset();
        #1 reset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) == 0, ($urandom % 10) == 0, 1'($urandom), 1'($urandom),
                  pick_reg(), {$urandom, $urandom}, pick_reg(), pick_reg());
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_wb_chain.md
Name: pipe_wb_chain

Overview:
- Parametrised successor to the single-stage write-back pipeline register of the pipelined CPU.
- Carries {valid, RegWrite, Rd, data} through DEPTH back-to-back stages.
- Adds global stall (hold), flush (bubble insertion) and a two-port forwarding lookup across all in-flight stages.
- Sits between the EX/MEM result path and the register file write port; the forwarding unit reads its lookup outputs.

Parameters:
- WIDTH, 64, data field width in bits.
- DEPTH, 2, number of pipeline stages (1..8); stage 0 is youngest, stage DEPTH-1 drives the outputs.
- ZERO_REG, 31, register number that is never written and never forwarded (XZR).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all stages this cycle.
- flush  input  1  kill all in-flight entries.
- in_valid  input  1  entry presented at stage 0.
- in_RegWrite  input  1  entry writes the register file.
- in_Rd  input  5  destination register.
- in_data  input  WIDTH  write-back value.
- out_valid  output  1  stage DEPTH-1 valid.
- out_RegWrite  output  1  stage DEPTH-1 RegWrite AND valid.
- out_Rd  output  5  stage DEPTH-1 Rd.
- out_data  output  WIDTH  stage DEPTH-1 data.
- query_a, query_b  input  5  source registers to look up.
- fwd_hit_a, fwd_hit_b  output  1  a live producer exists for query.
- fwd_data_a, fwd_data_b  output  WIDTH  data of youngest matching producer, 0 on miss.
- perf_stall_cnt  output  32  stall-cycle counter (see Optional Feature).
- perf_kill_cnt  output  32  flushed-valid-entry counter (see Optional Feature).

Behaviour:
- Reset (async, immediate): every stage's valid, RegWrite, Rd and data = 0; all outputs 0; counters 0.
- Normal cycle (stall=0, flush=0): stage0 <= inputs; stage k <= stage k-1; latency exactly DEPTH clocks input-to-output.
- stall=1, flush=0: every stage holds its contents; inputs are ignored and dropped (upstream must hold).
- flush=1: next edge clears valid and RegWrite in all stages including the incoming entry; Rd/data may hold. Flush has priority over stall.
- Live producer: stage k with valid=1, RegWrite=1 and Rd != ZERO_REG.
- Lookup: combinational, same cycle. Compares query against every live producer.
  - Youngest matching stage wins: lowest k.
  - query == ZERO_REG: always a miss.
- out_RegWrite is gated by valid, so the register file never writes on a bubble.
- in_RegWrite with in_valid=0 is stored as RegWrite=0.
- DEPTH=1: behaviour identical to a plain write-back register plus stall/flush.
- Reset asserted mid-stall or mid-flush: reset wins; state returns to reset values.

Optional Feature:
- Macro: PIPE_WB_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every clock with stall=1 and flush=0.
  - perf_kill_cnt increments by the number of valid stages (plus 1 if in_valid) discarded by each flush.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by reset.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
- Reset then three normal cycles with DEPTH=2: inject (Rd=5, data=0xAA, RegWrite=1) -> appears on out_* exactly 2 clocks later with out_RegWrite=1.
- Stall hold: with Rd=5 in stage0, hold stall=1 for 3 cycles while driving Rd=7 -> outputs unchanged for 3 cycles; Rd=7 never appears; Rd=5 emerges 1 clock after stall drops.
- Flush with stall: stage0=Rd3, stage1=Rd4, assert flush and stall together -> next cycle out_valid=0, out_RegWrite=0, both fwd_hit=0; perf_kill_cnt=3 if in_valid=1 (macro on).
- Forwarding priority: stage0 (Rd=9, data=0x22), stage1 (Rd=9, data=0x11), query_a=9 -> fwd_hit_a=1, fwd_data_a=0x22.
- ZERO_REG and RegWrite=0 exclusion: stage with Rd=31 RegWrite=1, another with Rd=8 RegWrite=0; query_a=31, query_b=8 -> both hits 0, both data 0.
- Async reset mid-operation: assert reset between clock edges with full pipeline -> all outputs 0 before the next edge; perf counters 0.
